syscall_unit: RTL and testbench



---
 rtl/syscall_unit_pkg.sv | 18 +
 rtl/syscall_unit_if.sv | 12 +
 rtl/syscall_unit.sv | 103 ++++++++++
 tb/tb_syscall_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/syscall_unit_pkg.sv
// Shared state encodings and syscall codes for the syscall unit.
package syscall_unit_pkg;

    localparam int SYS_DATA_W = 32;
    localparam int SYS_CNT_W  = 16;
    localparam int SYS_ST_BIT = 2;

    localparam int SYS_V0_PRINT_DEC = 1;
    localparam int SYS_V0_HALT      = 10;
    localparam int SYS_V0_PRINT_HEX = 34;

    typedef enum logic [SYS_ST_BIT-1:0] {
        SYS_ST_IDLE = 2'd0,
        SYS_ST_SEND = 2'd1,
        SYS_ST_HALT = 2'd2
    } sys_state_e;

endpackage

// File: rtl/syscall_unit_if.sv
// Valid/ready display handshake between the syscall unit and the console sink.
interface syscall_unit_if #(
    parameter int DATA_W = syscall_unit_pkg::SYS_DATA_W
);
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              disp_hex;
    logic              disp_ready;

    modport master (output disp_valid, output disp_data, output disp_hex, input disp_ready);
    modport slave  (input disp_valid, input disp_data, input disp_hex, output disp_ready);
endinterface

// File: rtl/syscall_unit.sv
// Services halt / print-dec / print-hex syscalls; stalls the front-end while busy.
module syscall_unit
    import syscall_unit_pkg::*;
#(
    parameter int                DATA_W       = SYS_DATA_W,
    parameter int                CNT_W        = SYS_CNT_W,
    parameter logic [DATA_W-1:0] V0_PRINT_DEC = DATA_W'(SYS_V0_PRINT_DEC),
    parameter logic [DATA_W-1:0] V0_HALT      = DATA_W'(SYS_V0_HALT),
    parameter logic [DATA_W-1:0] V0_PRINT_HEX = DATA_W'(SYS_V0_PRINT_HEX)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               syscall_en_i,
    input  logic               inst_valid_i,
    input  logic [DATA_W-1:0]  v0_data_i,
    input  logic [DATA_W-1:0]  a0_data_i,
    input  logic               resume_i,
    syscall_unit_if.master     disp,
    output logic               stall_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   sys_count_o
);

    sys_state_e        state_q, state_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_hex_q, disp_hex_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic is_print;

    assign accept   = syscall_en_i && inst_valid_i && (state_q == SYS_ST_IDLE);
    assign is_print = (v0_data_i == V0_PRINT_DEC) || (v0_data_i == V0_PRINT_HEX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYS_ST_IDLE;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_hex_q   <= 1'b0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            disp_hex_q   <= disp_hex_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        disp_hex_d   = disp_hex_q;
        halted_d     = halted_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            SYS_ST_IDLE: begin
                // Unknown v0 codes fall through as a NOP.
                if (accept && is_print) begin
                    disp_data_d  = a0_data_i;
                    disp_hex_d   = (v0_data_i == V0_PRINT_HEX);
                    disp_valid_d = 1'b1;
                    state_d      = SYS_ST_SEND;
                end else if (accept && (v0_data_i == V0_HALT)) begin
                    halted_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = SYS_ST_HALT;
                end
            end
            SYS_ST_SEND: begin
                if (disp.disp_ready) begin
                    disp_valid_d = 1'b0;
                    cnt_d        = cnt_q + CNT_W'(1);
                    state_d      = SYS_ST_IDLE;
                end
            end
            SYS_ST_HALT: begin
                if (resume_i) begin
                    halted_d = 1'b0;
                    state_d  = SYS_ST_IDLE;
                end
            end
            default: state_d = SYS_ST_IDLE;
        endcase
    end

    // Stall comes from registered state only, never from syscall_en.
    always_comb begin
        stall_o         = (state_q != SYS_ST_IDLE);
        halted_o        = halted_q;
        sys_count_o     = cnt_q;
        disp.disp_valid = disp_valid_q;
        disp.disp_data  = disp_data_q;
        disp.disp_hex   = disp_hex_q;
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit; a second instance with CNT_W=2 covers counter wrap.
module tb_syscall_unit;
    import syscall_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, iv = 1'b1, resume = 1'b0, rdy = 1'b0;
    logic [31:0] v0 = '0, a0 = '0;
    logic        stall, halted, stall2, halted2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_chk = 0;
    int n_err = 0;

    syscall_unit_if #(.DATA_W(32)) dif ();
    syscall_unit_if #(.DATA_W(32)) dif2 ();
    assign dif.disp_ready  = rdy;
    assign dif2.disp_ready = rdy;

    always #5 clk = ~clk;

    syscall_unit dut (
        .clk(clk), .rst_n(rst_n), .syscall_en_i(en), .inst_valid_i(iv),
        .v0_data_i(v0), .a0_data_i(a0), .resume_i(resume), .disp(dif.master),
        .stall_o(stall), .halted_o(halted), .sys_count_o(cnt)
    );

    syscall_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .syscall_en_i(en), .inst_valid_i(iv),
        .v0_data_i(v0), .a0_data_i(a0), .resume_i(resume), .disp(dif2.master),
        .stall_o(stall2), .halted_o(halted2), .sys_count_o(cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; resume = 1'b0; rdy = 1'b0; iv = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle_ok(input string tag, input logic [15:0] c);
        chk({tag, "_valid"}, dif.disp_valid, 1'b0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_cnt"}, cnt, c);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", dif.disp_valid, 1'b0);
        chk("rst_data", dif.disp_data, 32'h0);
        chk("rst_hex", dif.disp_hex, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cnt", cnt, 16'h0);
        tick();
        rst_n = 1'b1;

        // Print decimal, sink already ready
        v0 = 32'd1; a0 = 32'h2A; en = 1'b1; rdy = 1'b1;
        tick();
        en = 1'b0;
        chk("dec_valid", dif.disp_valid, 1'b1);
        chk("dec_data", dif.disp_data, 32'd42);
        chk("dec_hex", dif.disp_hex, 1'b0);
        chk("dec_stall", stall, 1'b1);
        chk("dec_cnt0", cnt, 16'd0);
        tick();
        idle_ok("dec_done", 16'd1);

        // Print hex under backpressure; a stray syscall during SEND is ignored
        do_reset();
        v0 = 32'd34; a0 = 32'hDEADBEEF; en = 1'b1; rdy = 1'b0;
        tick();
        v0 = 32'd1; a0 = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            chk("hex_valid", dif.disp_valid, 1'b1);
            chk("hex_data", dif.disp_data, 32'hDEADBEEF);
            chk("hex_hex", dif.disp_hex, 1'b1);
            chk("hex_stall", stall, 1'b1);
            chk("hex_cnt", cnt, 16'd0);
            tick();
        end
        en = 1'b0; rdy = 1'b1;
        tick();
        idle_ok("hex_done", 16'd1);
        rdy = 1'b0;
        tick();
        idle_ok("hex_after", 16'd1);

        // Halt; resume in the accepting cycle is ignored
        do_reset();
        v0 = 32'd10; en = 1'b1; resume = 1'b1; rdy = 1'b1;
        tick();
        resume = 1'b0; v0 = 32'd1; a0 = 32'h55;
        chk("halt_halted", halted, 1'b1);
        chk("halt_stall", stall, 1'b1);
        chk("halt_cnt", cnt, 16'd1);
        for (int i = 0; i < 18; i++) tick();
        en = 1'b0;
        chk("halt_hold", halted, 1'b1);
        chk("halt_hold_stall", stall, 1'b1);
        chk("halt_no_disp", dif.disp_valid, 1'b0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        idle_ok("resume", 16'd1);

        // Ignored requests
        do_reset();
        v0 = 32'd5; en = 1'b1;
        tick();
        idle_ok("nop_v0", 16'd0);
        v0 = 32'h0001_0001;
        tick();
        idle_ok("nop_upper", 16'd0);
        v0 = 32'd1; iv = 1'b0;
        tick();
        idle_ok("nop_iv", 16'd0);
        en = 1'b0; iv = 1'b1; resume = 1'b1;
        tick();
        resume = 1'b0;
        idle_ok("nop_resume", 16'd0);

        // Asynchronous reset mid-SEND
        v0 = 32'd1; a0 = 32'd7; en = 1'b1; rdy = 1'b1;
        tick();
        en = 1'b0;
        tick();
        chk("ar_cnt_pre", cnt, 16'd1);
        rdy = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        chk("ar_valid_pre", dif.disp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", dif.disp_valid, 1'b0);
        chk("ar_stall", stall, 1'b0);
        chk("ar_cnt", cnt, 16'd0);
        chk("ar_data", dif.disp_data, 32'd0);
        tick();
        rst_n = 1'b1;

        // Counter wrap on the CNT_W=2 instance
        rdy = 1'b1; v0 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_c;
            exp_c = 2'(i + 1);
            a0 = 32'(i);
            en = 1'b1;
            tick();
            en = 1'b0;
            chk("wrap_valid", dif2.disp_valid, 1'b1);
            tick();
            chk("wrap_cnt", cnt2, exp_c);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
